// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stage load enables for memory stalls, load-use interlocks and branch flushes.
// Optional stall/bubble performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 de_valid,
    input  logic                 de_uses_src2,
    input  logic [2:0]           src1,
    input  logic [2:0]           src2,
    input  logic                 ex_valid,
    input  logic                 ex_is_load,
    input  logic [2:0]           ex_dest,
    input  logic                 br_taken,
    output logic                 pc_load,
    output logic                 de_load,
    output logic                 ex_load,
    output logic                 mem_load,
    output logic                 de_valid_in,
    output logic                 ex_bubble,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_STALL = 2'd1,
        ST_FLUSH     = 2'd2
    } state_e;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    // A single-slot flush is fully covered by the branch cycle itself.
    localparam state_e     BR_NEXT    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    state_e     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       advance;
    logic       load_use;

    assign advance  = imem_resp & (~dmem_req | dmem_resp);
    assign load_use = ex_valid & ex_is_load & de_valid &
                      ((ex_dest == src1) | (de_uses_src2 & (ex_dest == src2)));

    // Next-state, flush countdown and load-enable decode.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pc_load     = 1'b0;
        de_load     = 1'b0;
        ex_load     = 1'b0;
        mem_load    = 1'b0;
        de_valid_in = 1'b1;
        ex_bubble   = 1'b0;
        case (state_q)
            ST_RUN, ST_MEM_STALL: begin
                if (!advance) begin
                    state_d = ST_MEM_STALL;
                end else if (br_taken) begin
                    {pc_load, de_load, ex_load, mem_load} = 4'b1111;
                    de_valid_in = 1'b0;
                    ex_bubble   = 1'b1;
                    flush_cnt_d = FLUSH_INIT;
                    state_d     = BR_NEXT;
                end else if (load_use) begin
                    {pc_load, de_load, ex_load, mem_load} = 4'b0011;
                    ex_bubble = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    {pc_load, de_load, ex_load, mem_load} = 4'b1111;
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                de_valid_in = 1'b0;
                if (!advance) begin
                    state_d = ST_FLUSH;
                end else if (br_taken) begin
                    {pc_load, de_load, ex_load, mem_load} = 4'b1111;
                    ex_bubble   = 1'b1;
                    flush_cnt_d = FLUSH_INIT;
                    state_d     = BR_NEXT;
                end else begin
                    {pc_load, de_load, ex_load, mem_load} = 4'b1111;
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    state_d     = (flush_cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    // State and flush counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating increments for the performance counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!advance && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (ex_bubble && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= {CNT_WIDTH{1'b0}};
            bubble_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = {CNT_WIDTH{1'b0}};
    assign bubble_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a slot-counting reference model.
module tb_pipe_hazard_ctrl;

    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int SAT  = (1 << CW) - 1;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_resp, dmem_req, dmem_resp;
    logic          de_valid, de_uses_src2;
    logic [2:0]    src1, src2, ex_dest;
    logic          ex_valid, ex_is_load, br_taken;
    logic          pc_load, de_load, ex_load, mem_load;
    logic          de_valid_in, ex_bubble;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int vec_cnt  = 0;
    int fail_cnt = 0;
    int squash_left = 0;
    int stall_exp   = 0;
    int bubble_exp  = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .de_valid(de_valid), .de_uses_src2(de_uses_src2),
        .src1(src1), .src2(src2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
        .br_taken(br_taken),
        .pc_load(pc_load), .de_load(de_load), .ex_load(ex_load), .mem_load(mem_load),
        .de_valid_in(de_valid_in), .ex_bubble(ex_bubble),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic set_idle();
        imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
        de_valid = 1'b1; de_uses_src2 = 1'b1; src1 = 3'd1; src2 = 3'd2;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_dest = 3'd0; br_taken = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic run_cycle(input string tag);
        bit adv, lu, bub_now;
        int next_squash;
        @(negedge clk);
        adv = imem_resp && (!dmem_req || dmem_resp);
        lu  = ex_valid && ex_is_load && de_valid &&
              ((ex_dest == src1) || (de_uses_src2 && (ex_dest == src2)));
        bub_now = 1'b0;
        next_squash = squash_left;
        check_val({tag, ".stall_cnt"},  32'(stall_cnt),  PERF ? 32'(stall_exp)  : 32'd0);
        check_val({tag, ".bubble_cnt"}, 32'(bubble_cnt), PERF ? 32'(bubble_exp) : 32'd0);
        if (!adv) begin
            check_val({tag, ".loads"}, {28'd0, pc_load, de_load, ex_load, mem_load}, 32'h0);
        end else if (br_taken) begin
            check_val({tag, ".loads"}, {28'd0, pc_load, de_load, ex_load, mem_load}, 32'hF);
            check_val({tag, ".de_valid_in"}, {31'd0, de_valid_in}, 32'd0);
            check_val({tag, ".ex_bubble"}, {31'd0, ex_bubble}, 32'd1);
            bub_now = 1'b1;
            next_squash = FC - 1;
        end else if (squash_left > 0) begin
            check_val({tag, ".loads"}, {28'd0, pc_load, de_load, ex_load, mem_load}, 32'hF);
            check_val({tag, ".de_valid_in"}, {31'd0, de_valid_in}, 32'd0);
            next_squash = squash_left - 1;
        end else if (lu) begin
            check_val({tag, ".loads"}, {28'd0, pc_load, de_load, ex_load, mem_load}, 32'h3);
            check_val({tag, ".ex_bubble"}, {31'd0, ex_bubble}, 32'd1);
            bub_now = 1'b1;
        end else begin
            check_val({tag, ".loads"}, {28'd0, pc_load, de_load, ex_load, mem_load}, 32'hF);
            check_val({tag, ".de_valid_in"}, {31'd0, de_valid_in}, 32'd1);
            check_val({tag, ".ex_bubble"}, {31'd0, ex_bubble}, 32'd0);
        end
        @(posedge clk);
        if (rst_n) begin
            squash_left = next_squash;
            if (!adv && stall_exp < SAT) stall_exp++;
            if (bub_now && bubble_exp < SAT) bubble_exp++;
        end
        #1;
    endtask

    // Asynchronous reset pulse taken mid-cycle, released one edge later.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        squash_left = 0; stall_exp = 0; bubble_exp = 0;
        check_val("rst.stall_cnt",  32'(stall_cnt),  32'd0);
        check_val("rst.bubble_cnt", 32'(bubble_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        #1;
        check_val("por.stall_cnt",  32'(stall_cnt),  32'd0);
        check_val("por.bubble_cnt", 32'(bubble_cnt), 32'd0);
        run_cycle("por_run");
        rst_n = 1'b1;
        run_cycle("idle");

        // Load-use on src1, then the pipeline resumes.
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd3; src1 = 3'd3;
        run_cycle("lu_src1");
        ex_valid = 1'b0;
        run_cycle("lu_after");

        // Load dest matches src2 but src2 unused: no interlock.
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd5; src1 = 3'd1;
        src2 = 3'd5; de_uses_src2 = 1'b0;
        run_cycle("lu_nosrc2");
        de_uses_src2 = 1'b1;
        run_cycle("lu_src2");
        set_idle();

        // Taken branch: two squashed slots then valid again.
        br_taken = 1'b1;
        run_cycle("br0");
        br_taken = 1'b0;
        run_cycle("br1");
        run_cycle("br2");

        // Branch and load-use in the same cycle.
        br_taken = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd1;
        run_cycle("br_lu");
        set_idle();
        run_cycle("br_lu1");
        run_cycle("br_lu2");

        // Fetch stall for four cycles with a branch pending.
        pulse_reset();
        imem_resp = 1'b0; br_taken = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle("istall");
        imem_resp = 1'b1;
        run_cycle("istall_br");
        br_taken = 1'b0;
        run_cycle("istall_fl");
        run_cycle("istall_done");

        // Reset in the middle of a flush abandons it.
        br_taken = 1'b1;
        run_cycle("rf_br");
        br_taken = 1'b0;
        pulse_reset();
        run_cycle("rf_after");

        // Data memory stall then completion.
        dmem_req = 1'b1;
        run_cycle("dstall");
        dmem_resp = 1'b1;
        run_cycle("dresp");
        set_idle();

        for (int n = 0; n < 3000; n++) begin
            imem_resp    = ($urandom_range(0, 99) < 85);
            dmem_req     = ($urandom_range(0, 99) < 25);
            dmem_resp    = $urandom_range(0, 1);
            br_taken     = ($urandom_range(0, 99) < 8);
            de_valid     = ($urandom_range(0, 99) < 90);
            de_uses_src2 = $urandom_range(0, 1);
            src1         = 3'($urandom_range(0, 7));
            src2         = 3'($urandom_range(0, 7));
            ex_valid     = $urandom_range(0, 1);
            ex_is_load   = $urandom_range(0, 1);
            ex_dest      = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) pulse_reset();
            run_cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
